// File: rtl/pn_token_tx_pkg.sv
// Shared definitions for the PN token transmitter: modes, opcodes, token layout, FSM states.
package pn_pkg;

  typedef enum logic [1:0] {
    PRE_SORT_DESC = 2'd0,
    POST_SORT_ASC = 2'd1,
    PRE_STACK     = 2'd2,
    POST_STACK    = 2'd3
  } pn_mode_e;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    SUB     = 3'd1,
    MUL     = 3'd2,
    ABS_ADD = 3'd3
  } pn_opcode_e;

  localparam int unsigned PN_MAX_TOK = 12;
  localparam int unsigned PN_MAX_RES = 4;
  localparam int unsigned PN_TIMEOUT = 64;

  typedef struct packed {
    logic       op;
    logic [2:0] val;
  } pn_tok_t;

  // ST_CHECK is only reachable when the format checker is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4,
    ST_CHECK   = 3'd5
  } pn_state_e;

endpackage

// File: rtl/pn_token_tx_if.sv
// Token/result bus between the transmitter (master) and the PN evaluator (slave).
interface pn_token_tx_if;
  logic               pn_in_valid;
  logic [1:0]         pn_mode;
  logic               pn_operator;
  logic [2:0]         pn_in;
  logic               pn_out_valid;
  logic signed [31:0] pn_out;

  modport master (
    output pn_in_valid, pn_mode, pn_operator, pn_in,
    input  pn_out_valid, pn_out
  );

  modport slave (
    input  pn_in_valid, pn_mode, pn_operator, pn_in,
    output pn_out_valid, pn_out
  );
endinterface

// File: rtl/pn_token_tx_fmt_check.sv
// Combinational frame format checker; exists only in builds with PN_TX_CHECK_EN.
`ifdef PN_TX_CHECK_EN
module pn_fmt_check
  import pn_pkg::*;
#(
  parameter int unsigned MAX_TOK = PN_MAX_TOK
) (
  input  pn_tok_t [MAX_TOK-1:0] toks_i,
  input  logic [3:0]            count_i,
  input  logic [1:0]            mode_i,
  output logic                  ok_o
);

  logic        exp_op;
  logic [3:0]  ix;
  int unsigned depth;

  always_comb begin
    ok_o   = 1'b1;
    exp_op = 1'b0;
    ix     = '0;
    depth  = 0;
    case (mode_i)
      PRE_SORT_DESC, POST_SORT_ASC: begin
        if (count_i % 4'd3 != 4'd0) ok_o = 1'b0;
        for (int unsigned i = 0; i < MAX_TOK; i++) begin
          ix = 4'(i);
          if (ix < count_i) begin
            exp_op = (mode_i == PRE_SORT_DESC) ? (i % 3 == 0) : (i % 3 == 2);
            if (toks_i[ix].op != exp_op) ok_o = 1'b0;
          end
        end
      end
      default: begin
        // Prefix scans right-to-left, postfix left-to-right; every operator is binary.
        for (int unsigned j = 0; j < MAX_TOK; j++) begin
          ix = (mode_i == PRE_STACK) ? 4'(MAX_TOK - 1 - j) : 4'(j);
          if (ix < count_i) begin
            if (!toks_i[ix].op) depth = depth + 1;
            else if (depth < 2) ok_o = 1'b0;
            else depth = depth - 1;
          end
        end
        if (depth != 1) ok_o = 1'b0;
      end
    endcase
  end

endmodule
`endif

// File: rtl/pn_token_tx.sv
// PN token transmitter: buffers host tokens, streams a frame to the evaluator, forwards results.
// Optional build macro PN_TX_CHECK_EN adds a one-cycle frame format check before sending.
module pn_token_tx
  import pn_pkg::*;
#(
  parameter int unsigned MAX_TOK = PN_MAX_TOK,
  parameter int unsigned MAX_RES = PN_MAX_RES,
  parameter int unsigned TIMEOUT = PN_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_op,
  input  logic [2:0]       wr_val,
  input  logic             start,
  input  logic [1:0]       start_mode,
  output logic [3:0]       tok_count,
  output logic             busy,
  pn_token_tx_if.master    pn,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [1:0]       res_idx,
  output logic [2:0]       res_count,
  output logic             done,
  output logic             load_err,
  output logic             timeout_err,
  output logic             fmt_err
);

  localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  MAX_TOK_C = 4'(MAX_TOK);
  localparam logic [2:0]  MAX_RES_C = 3'(MAX_RES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  pn_state_e               state_q;
  pn_tok_t [MAX_TOK-1:0]   buf_q;
  logic [3:0]              tok_cnt_q;
  logic [3:0]              send_idx_q;
  logic [TW-1:0]           timer_q;
  logic [2:0]              beat_q;
  logic                    pv_q, pop_q;
  logic [2:0]              pin_q;
  logic [1:0]              pmode_q;
  logic                    res_valid_q;
  logic [31:0]             res_data_q;
  logic [1:0]              res_idx_q;
  logic [2:0]              res_count_q;
  logic                    done_q, load_err_q, timeout_err_q;

  pn_tok_t    new_tok, tok0;
  logic       wr_ok, start_ok;
  logic [3:0] tok_cnt_d, next_idx;

  always_comb begin
    new_tok   = '{op: wr_op, val: wr_val};
    wr_ok     = (state_q == ST_IDLE) && wr_en && (tok_cnt_q < MAX_TOK_C);
    tok_cnt_d = wr_ok ? tok_cnt_q + 4'd1 : tok_cnt_q;
    start_ok  = (state_q == ST_IDLE) && start && (tok_cnt_d != 4'd0);
    // A write in the start cycle into an empty buffer must become beat 0 directly.
    tok0      = (wr_ok && tok_cnt_q == 4'd0) ? new_tok : buf_q[0];
    next_idx  = send_idx_q + 4'd1;
  end

`ifdef PN_TX_CHECK_EN
  logic [1:0] mode_q;
  logic       fmt_ok;
  logic       fmt_err_q;

  pn_fmt_check #(.MAX_TOK(MAX_TOK)) u_fmt_check (
    .toks_i  (buf_q),
    .count_i (tok_cnt_q),
    .mode_i  (mode_q),
    .ok_o    (fmt_ok)
  );
  assign fmt_err = fmt_err_q;
`else
  assign fmt_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      tok_cnt_q     <= '0;
      send_idx_q    <= '0;
      timer_q       <= '0;
      beat_q        <= '0;
      pv_q          <= 1'b0;
      pop_q         <= 1'b0;
      pin_q         <= '0;
      pmode_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      res_count_q   <= '0;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef PN_TX_CHECK_EN
      mode_q        <= '0;
      fmt_err_q     <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      if (wr_en && state_q != ST_IDLE) load_err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (wr_ok) begin
            buf_q[tok_cnt_q] <= new_tok;
            tok_cnt_q        <= tok_cnt_d;
          end else if (wr_en) begin
            load_err_q <= 1'b1;
          end
          if (start_ok) begin
            load_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            res_count_q   <= '0;
`ifdef PN_TX_CHECK_EN
            fmt_err_q     <= 1'b0;
            mode_q        <= start_mode;
            state_q       <= ST_CHECK;
`else
            pv_q          <= 1'b1;
            pmode_q       <= start_mode;
            pop_q         <= tok0.op;
            pin_q         <= tok0.val;
            send_idx_q    <= '0;
            state_q       <= ST_SEND;
`endif
          end
        end

`ifdef PN_TX_CHECK_EN
        ST_CHECK: begin
          if (fmt_ok) begin
            pv_q       <= 1'b1;
            pmode_q    <= mode_q;
            pop_q      <= buf_q[0].op;
            pin_q      <= buf_q[0].val;
            send_idx_q <= '0;
            state_q    <= ST_SEND;
          end else begin
            fmt_err_q <= 1'b1;
            done_q    <= 1'b1;
            tok_cnt_q <= '0;
            state_q   <= ST_DONE;
          end
        end
`endif

        ST_SEND: begin
          if (next_idx < tok_cnt_q) begin
            pop_q      <= buf_q[next_idx].op;
            pin_q      <= buf_q[next_idx].val;
            send_idx_q <= next_idx;
          end else begin
            pv_q    <= 1'b0;
            pmode_q <= '0;
            pop_q   <= 1'b0;
            pin_q   <= '0;
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (pn.pn_out_valid) begin
            res_valid_q <= 1'b1;
            res_data_q  <= pn.pn_out;
            res_idx_q   <= '0;
            res_count_q <= 3'd1;
            beat_q      <= 3'd1;
            state_q     <= ST_COLLECT;
          end else if (timer_q == TMO_LAST) begin
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
            tok_cnt_q     <= '0;
            state_q       <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_COLLECT: begin
          if (pn.pn_out_valid) begin
            if (beat_q < MAX_RES_C) begin
              res_valid_q <= 1'b1;
              res_data_q  <= pn.pn_out;
              res_idx_q   <= beat_q[1:0];
              res_count_q <= beat_q + 3'd1;
              beat_q      <= beat_q + 3'd1;
            end
          end else begin
            done_q    <= 1'b1;
            tok_cnt_q <= '0;
            state_q   <= ST_DONE;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tok_count      = tok_cnt_q;
  assign busy           = (state_q != ST_IDLE);
  assign pn.pn_in_valid = pv_q;
  assign pn.pn_mode     = pmode_q;
  assign pn.pn_operator = pop_q;
  assign pn.pn_in       = pin_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_idx        = res_idx_q;
  assign res_count      = res_count_q;
  assign done           = done_q;
  assign load_err       = load_err_q;
  assign timeout_err    = timeout_err_q;

endmodule
